// File: rtl/norm_pkg.sv
// norm_pkg: types and constants shared by the norm_128 normalizer and its bench.
//   norm_state_t  : FSM encoding (IDLE, SHIFT, DONE)
//   NORM_W        : mantissa width (128)
//   NORM_CW       : shift-count width, also the number of shifter stages (7)
//   norm_cycles() : SHIFT-state cycles needed for a given stages-per-cycle
package norm_pkg;

    localparam int NORM_W  = 128;
    localparam int NORM_CW = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } norm_state_t;

    // ceil(NORM_CW / spc)
    function automatic int norm_cycles(input int spc);
        return (NORM_CW + spc - 1) / spc;
    endfunction

endpackage

// File: rtl/lzc_128.sv
// lzc_128: combinational 128-bit leading-zero counter.
//   a : input vector
//   c : number of zeros above the most significant set bit (0 when a == 0)
//   v : 1 when a has at least one set bit
module lzc_128
    import norm_pkg::*;
(
    input  logic [NORM_W-1:0]  a,
    output logic [NORM_CW-1:0] c,
    output logic               v
);

    // Ascending scan: the highest set bit is the last one to write c.
    always_comb begin
        c = '0;
        for (int i = 0; i < NORM_W; i++) begin
            if (a[i]) c = NORM_CW'(NORM_W - 1 - i);
        end
    end

    assign v = |a;

endmodule

// File: rtl/norm_128.sv
// norm_128: sequential 128-bit left-normalizer.
// Accepts a mantissa/exponent pair on a valid/ready handshake, shifts the
// mantissa left until bit 127 is set using an iterative logarithmic shifter
// (SPC stages per cycle), and returns the normalized mantissa, adjusted
// exponent, applied shift and status flags.
//
// Ports:
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready     : request handshake (in_ready only in IDLE)
//   a_i, e_i                : unnormalized mantissa, signed exponent
//   out_valid / out_ready   : result handshake (held in DONE)
//   m_o, e_o, sh_o          : normalized mantissa, adjusted exponent, shift
//   zero_o, uf_o            : input was zero, exponent underflow
//
// Optional feature macro: NORM_SUBNORMAL_LIMIT_EN
//   When defined, the shift is clamped so the exponent does not go below
//   EMIN (result stays subnormal) and uf_o is tied low.
module norm_128
    import norm_pkg::*;
#(
    parameter int EW   = 14,
    parameter int SPC  = 1,
    parameter int EMIN = -16382
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NORM_W-1:0]  a_i,
    input  logic [EW-1:0]      e_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NORM_W-1:0]  m_o,
    output logic [EW-1:0]      e_o,
    output logic [NORM_CW-1:0] sh_o,
    output logic               zero_o,
    output logic               uf_o
);

    localparam int N = norm_cycles(SPC);

    norm_state_t state, state_n;

    logic [2:0]         cnt;     // SHIFT cycle index
    logic [3:0]         k;       // first stage applied this cycle
    logic [NORM_CW-1:0] c;
    logic               v;
    logic [NORM_CW-1:0] s_n;
    logic [EW-1:0]      e_n;
    logic               uf_n;
    logic [NORM_W-1:0]  m_shift;

    lzc_128 u_lzc (
        .a (a_i),
        .c (c),
        .v (v)
    );

    // Shift amount and exponent, evaluated on the live inputs at accept time.
`ifdef NORM_SUBNORMAL_LIMIT_EN
    logic signed [EW+1:0] headroom;  // e_i - EMIN, wide enough to not wrap
    logic signed [EW+1:0] c_x;

    always_comb begin
        headroom = (EW+2)'($signed(e_i)) - (EW+2)'(EMIN);
        c_x      = $signed({{(EW-5){1'b0}}, c});
        if (!v || headroom <= 0)
            s_n = '0;
        else if (headroom < c_x)
            s_n = headroom[NORM_CW-1:0];
        else
            s_n = c;
        e_n  = e_i - EW'(s_n);
        uf_n = 1'b0;
    end
`else
    logic [EW:0] e_full;  // one guard bit to detect the low-side wrap

    always_comb begin
        s_n    = v ? c : '0;
        e_full = {e_i[EW-1], e_i} - (EW+1)'(s_n);
        e_n    = e_full[EW-1:0];
        // Subtracting a non-negative amount can only overflow downwards.
        uf_n   = e_full[EW] ^ e_full[EW-1];
    end
`endif

    // One SHIFT cycle: apply stages k .. min(k+SPC,7)-1 of the stored shift.
    assign k = 4'(cnt) * 4'(SPC);

    always_comb begin
        m_shift = m_o;
        for (int j = 0; j < NORM_CW; j++) begin
            if ((4'(j) >= k) && (4'(j) < k + 4'(SPC)) && sh_o[j])
                m_shift = m_shift << (1 << j);
        end
    end

    // FSM
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = SHIFT;
            end
            SHIFT: begin
                if (cnt == 3'(N - 1)) state_n = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath: m_o doubles as the working shift register; it only moves in
    // SHIFT, so it is frozen throughout DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt    <= '0;
            m_o    <= '0;
            e_o    <= '0;
            sh_o   <= '0;
            zero_o <= 1'b0;
            uf_o   <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            cnt    <= '0;
            m_o    <= a_i;
            e_o    <= e_n;
            sh_o   <= s_n;
            zero_o <= ~v;
            uf_o   <= uf_n;
        end else if (state == SHIFT) begin
            cnt    <= cnt + 3'd1;
            m_o    <= m_shift;
        end
    end

endmodule

// File: tb/tb_norm_128.sv
module tb_norm_128;
    import norm_pkg::*;

    localparam int EW   = 14;
    localparam int SPC  = 1;
    localparam int EMIN = -8190;
    localparam int N    = norm_cycles(SPC);

    logic               clock = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [NORM_W-1:0]  a_i;
    logic [EW-1:0]      e_i;
    logic               out_valid;
    logic               out_ready;
    logic [NORM_W-1:0]  m_o;
    logic [EW-1:0]      e_o;
    logic [NORM_CW-1:0] sh_o;
    logic               zero_o;
    logic               uf_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    norm_128 #(.EW(EW), .SPC(SPC), .EMIN(EMIN)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_i       (a_i),
        .e_i       (e_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .m_o       (m_o),
        .e_o       (e_o),
        .sh_o      (sh_o),
        .zero_o    (zero_o),
        .uf_o      (uf_o)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: locate the top set bit, derive the shift from the rules,
    // then do the arithmetic on plain integers.
    task automatic model(input logic [127:0] a, input int e,
                         output logic [127:0] m, output logic [EW-1:0] eo,
                         output int sh, output bit z, output bit uf);
        int msb;
        int lz;
        int r;
        msb = -1;
        for (int i = 0; i < 128; i++) if (a[i]) msb = i;
        z  = (msb < 0);
        lz = z ? 0 : 127 - msb;
`ifdef NORM_SUBNORMAL_LIMIT_EN
        begin
            int lim;
            lim = e - EMIN;
            if (lim < 0) lim = 0;
            sh = (lz < lim) ? lz : lim;
            uf = 1'b0;
        end
`else
        sh = lz;
        uf = ((e - lz) < -(1 << (EW - 1)));
`endif
        r  = e - sh;
        eo = r[EW-1:0];
        m  = a << sh;
    endtask

    task automatic send(input logic [127:0] a, input int e);
        chk("in_ready_before", 128'(in_ready), 128'(1));
        a_i      = a;
        e_i      = e[EW-1:0];
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic check_res(input logic [127:0] a, input int e);
        logic [127:0]  m;
        logic [EW-1:0] eo;
        int sh;
        bit z, uf;
        model(a, e, m, eo, sh, z, uf);
        chk("m_o",    m_o,           m);
        chk("e_o",    128'(e_o),     128'(eo));
        chk("sh_o",   128'(sh_o),    128'(sh));
        chk("zero_o", 128'(zero_o),  128'(z));
        chk("uf_o",   128'(uf_o),    128'(uf));
    endtask

    // Full transaction; exp_sh >= 0 adds a hand-computed shift check.
    task automatic run(input logic [127:0] a, input int e, input int exp_sh, input int dly);
        int lat;
        send(a, e);
        wait_out(lat);
        chk("latency", 128'(lat), 128'(N));
        check_res(a, e);
        if (exp_sh >= 0) chk("sh_direct", 128'(sh_o), 128'(exp_sh));
        repeat (dly) begin
            @(posedge clock); #1;
            chk("ov_wait", 128'(out_valid), 128'(1));
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk("in_ready_after", 128'(in_ready), 128'(1));
        chk("ov_after",       128'(out_valid), 128'(0));
    endtask

    initial begin
        logic [127:0] a;
        logic [127:0] snap_m;
        logic [EW-1:0] snap_e;
        logic [NORM_CW-1:0] snap_sh;
        int e, lat;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_i = '0; e_i = '0;
        repeat (2) @(posedge clock); #1;
        chk("rst_ov",   128'(out_valid), 128'(0));
        chk("rst_m",    m_o,             128'(0));
        chk("rst_e",    128'(e_o),       128'(0));
        chk("rst_sh",   128'(sh_o),      128'(0));
        chk("rst_zero", 128'(zero_o),    128'(0));
        chk("rst_uf",   128'(uf_o),      128'(0));
        chk("rst_rdy",  128'(in_ready),  128'(1));
        reset = 1'b0;
        @(posedge clock); #1;

        // Directed cases
        run(128'(1), 200, 127, 0);
        chk("tp1_e", 128'(e_o), 128'(73));
        chk("tp1_m", m_o, {1'b1, 127'b0});
        run({1'b1, 127'b0}, -5, 0, 0);
        chk("tp2_e", 128'(e_o), 128'(14'h3FFB));
        run(128'(0), 9, 0, 1);
        chk("tp3_zero", 128'(zero_o), 128'(1));
        chk("tp3_e",    128'(e_o),    128'(9));
`ifdef NORM_SUBNORMAL_LIMIT_EN
        run(128'(1), -8150, 40, 0);
        chk("uf_m", m_o, 128'(1) << 40);
        chk("uf_e", 128'(e_o), 128'(14'(-8190)));
`else
        run(128'(1), -8150, 127, 0);
        chk("uf_flag", 128'(uf_o), 128'(1));
        chk("uf_e",    128'(e_o),  128'(14'(8107)));
`endif

        // Output held under back-pressure while in_valid toggles
        send(128'hF00, 7);
        wait_out(lat);
        chk("hs_lat", 128'(lat), 128'(N));
        snap_m = m_o; snap_e = e_o; snap_sh = sh_o;
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            a_i = {$urandom, $urandom, $urandom, $urandom};
            e_i = EW'($urandom);
            @(posedge clock); #1;
            chk("hs_ov",   128'(out_valid), 128'(1));
            chk("hs_rdy",  128'(in_ready),  128'(0));
            chk("hs_m",    m_o,             snap_m);
            chk("hs_e",    128'(e_o),       128'(snap_e));
            chk("hs_sh",   128'(sh_o),      128'(snap_sh));
        end
        in_valid = 1'b0;
        check_res(128'hF00, 7);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk("hs_rdy_next", 128'(in_ready),  128'(1));
        @(posedge clock); #1;
        chk("hs_no_second", 128'(out_valid), 128'(0));
        chk("hs_still_idle", 128'(in_ready), 128'(1));

        // Reset in the middle of SHIFT drops the request
        send(128'h1234, 50);
        repeat (2) begin @(posedge clock); #1; end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("mr_ov",   128'(out_valid), 128'(0));
        chk("mr_m",    m_o,             128'(0));
        chk("mr_e",    128'(e_o),       128'(0));
        chk("mr_sh",   128'(sh_o),      128'(0));
        chk("mr_zero", 128'(zero_o),    128'(0));
        chk("mr_uf",   128'(uf_o),      128'(0));
        chk("mr_rdy",  128'(in_ready),  128'(1));
        run(128'hF0, 100, 120, 0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            a = {$urandom, $urandom, $urandom, $urandom} >> $urandom_range(0, 127);
            if ($urandom_range(0, 9) == 0) a = '0;
            e = int'($urandom_range(0, 16383)) - 8192;
            run(a, e, -1, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
